// File: rtl/led_pattern_sequencer.sv
// Pattern player: steps a single-read-port ROM through Len entries at a programmable tick
// rate, with loop / one-shot / ping-pong / hold modes, and registers the fetched word onto Led.
module led_pattern_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DIV_W  = 24
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic              Stop,
    input  logic [1:0]        Mode,
    input  logic [DIV_W-1:0]  Div,
    input  logic [ADDR_W:0]   Len,
    output logic [ADDR_W-1:0] RomAddr,
    input  logic [DATA_W-1:0] RomData,
    output logic [DATA_W-1:0] Led,
    output logic              Busy,
    output logic              Done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [1:0] M_LOOP    = 2'b00;
    localparam logic [1:0] M_ONESHOT = 2'b01;
    localparam logic [1:0] M_PINGPONG = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              tick_c;
    logic              len_sat_c;
    logic [ADDR_W-1:0] len_last_c;

    // Out-of-range lengths (0 or above DEPTH) play the full ROM.
    always_comb begin
        len_sat_c  = (Len == '0) || (Len > (ADDR_W+1)'(DEPTH));
        len_last_c = len_sat_c ? {ADDR_W{1'b1}} : ADDR_W'(Len - (ADDR_W+1)'(1));
    end

    assign tick_c = (state_q == S_RUN) && (cnt_q == div_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pend_d  = 1'b0;
        led_d   = pend_q ? RomData : led_q;
        done_d  = 1'b0;

        if (Start && !Stop) begin
            state_d = S_RUN;
            addr_d  = '0;
            dir_d   = DIR_UP;
            cnt_d   = '0;
            div_d   = Div;
            last_d  = len_last_c;
            pend_d  = 1'b1;
        end else if (state_q == S_RUN) begin
            if (Stop) begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end else if (tick_c) begin
                cnt_d = '0;
                unique case (Mode)
                    M_LOOP: begin
                        dir_d  = DIR_UP;
                        addr_d = (addr_q == last_q) ? '0 : addr_q + ADDR_W'(1);
                        pend_d = 1'b1;
                    end
                    M_ONESHOT: begin
                        dir_d = DIR_UP;
                        if (addr_q == last_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                            pend_d = 1'b1;
                        end
                    end
                    M_PINGPONG: begin
                        pend_d = 1'b1;
                        // Single-entry pattern has nowhere to bounce to.
                        if (last_q == '0) begin
                            addr_d = '0;
                        end else if (dir_q == DIR_UP) begin
                            if (addr_q == last_q) begin
                                dir_d  = DIR_DOWN;
                                addr_d = addr_q - ADDR_W'(1);
                            end else begin
                                addr_d = addr_q + ADDR_W'(1);
                            end
                        end else begin
                            if (addr_q == '0) begin
                                dir_d  = DIR_UP;
                                addr_d = ADDR_W'(1);
                            end else begin
                                addr_d = addr_q - ADDR_W'(1);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        busy_d = (state_d == S_RUN);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            pend_q  <= 1'b0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign RomAddr = addr_q;
    assign Led     = led_q;
    assign Busy    = busy_q;
    assign Done    = done_q;

endmodule
